// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue unit: opcode and condition codes,
// FSM state encoding, instruction field positions, and opcode-class helpers.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_XOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0011,
    OP_CMP = 4'b0100,
    OP_CMN = 4'b0101,
    OP_MOV = 4'b0110,
    OP_B   = 4'b0111,
    OP_LD  = 4'b1000,
    OP_ST  = 4'b1001,
    OP_BEQ = 4'b1010,
    OP_BNE = 4'b1011
  } opcode_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_MI = 4'b0001;
  localparam logic [3:0] COND_VS = 4'b0010;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam int unsigned F_COND_HI = 31;
  localparam int unsigned F_COND_LO = 28;
  localparam int unsigned F_OP_HI   = 27;
  localparam int unsigned F_OP_LO   = 24;
  localparam int unsigned F_S       = 23;
  localparam int unsigned F_RD_HI   = 22;
  localparam int unsigned F_RD_LO   = 20;
  localparam int unsigned F_RN_HI   = 19;
  localparam int unsigned F_RN_LO   = 17;
  localparam int unsigned F_RM_HI   = 16;
  localparam int unsigned F_RM_LO   = 14;
  localparam int unsigned F_IMM_SEL = 13;
  localparam int unsigned F_IMM_HI  = 7;
  localparam int unsigned F_IMM_LO  = 0;

  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] opcode;
    logic       s;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    logic       imm_sel;
    logic [7:0] imm8;
  } instr_fields_t;

  function automatic logic op_is_branch(input logic [3:0] op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_XOR) || (op == OP_SUB) ||
           (op == OP_ADD) || (op == OP_MOV) || (op == OP_LD);
  endfunction

  // 1100-1111 are unassigned and retire as no-ops
  function automatic logic op_defined(input logic [3:0] op);
    return op[3:2] != 2'b11;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8 x 8-bit register file for the ALU issue unit.
// Ports: clk/rst (sync, active-high, clears all registers); we/waddr/wdata
// synchronous write port; raddr_a/rdata_a and raddr_b/rdata_b combinational
// read ports.
module alu_issue_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end for an external 8-bit ALU.
// Accepts one instruction in IDLE, presents decoded operands to the ALU in
// EXEC, captures the ALU result, and retires in WB (register/CPSR/pc update).
// Ports: clk, rst (sync, active-high); instr_valid/instr/instr_ready issue
// handshake; alu_* / cond_* / cond_update / branch / riscv_branch_offset
// drive the ALU; alu_out/alu_flags/alu_cpsr_write/alu_cond_satisfy return
// from it; pc, cpsr, busy, wb_valid report architectural state.
module alu_issue_unit
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_control,
  output logic [3:0]  alu_inst_conds,
  output logic        cond_is_zero,
  output logic        cond_is_negative,
  output logic        cond_is_overflow,
  output logic        cond_is_always,
  output logic        cond_update,
  output logic        branch,
  output logic [7:0]  riscv_branch_offset,
  output logic [7:0]  alu_pc,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  input  logic        alu_cpsr_write,
  input  logic        alu_cond_satisfy,
  output logic [7:0]  pc,
  output logic [3:0]  cpsr,
  output logic        busy,
  output logic        wb_valid
);

  state_e        state, state_next;
  instr_fields_t iq;
  logic [7:0]    res_out;
  logic [3:0]    res_flags;
  logic          res_cpsr_write;
  logic          res_cond_sat;
  logic [7:0]    rdata_a, rdata_b;
  logic          reg_we;
  logic          unused_bits;

  assign unused_bits = ^instr[12:8];

  alu_issue_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (reg_we),
    .waddr   (iq.rd),
    .wdata   (res_out),
    .raddr_a (iq.rn),
    .rdata_a (rdata_a),
    .raddr_b (iq.rm),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      iq             <= '0;
      res_out        <= '0;
      res_flags      <= '0;
      res_cpsr_write <= 1'b0;
      res_cond_sat   <= 1'b0;
      pc             <= '0;
      cpsr           <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            iq.cond    <= instr[F_COND_HI:F_COND_LO];
            iq.opcode  <= instr[F_OP_HI:F_OP_LO];
            iq.s       <= instr[F_S];
            iq.rd      <= instr[F_RD_HI:F_RD_LO];
            iq.rn      <= instr[F_RN_HI:F_RN_LO];
            iq.rm      <= instr[F_RM_HI:F_RM_LO];
            iq.imm_sel <= instr[F_IMM_SEL];
            iq.imm8    <= instr[F_IMM_HI:F_IMM_LO];
          end
        end
        S_EXEC: begin
          res_out        <= alu_out;
          res_flags      <= alu_flags;
          res_cpsr_write <= alu_cpsr_write;
          res_cond_sat   <= alu_cond_satisfy;
        end
        S_WB: begin
          if (op_defined(iq.opcode) && res_cond_sat && res_cpsr_write)
            cpsr <= res_flags;
          if (res_cond_sat && op_is_branch(iq.opcode))
            pc <= res_out;
          else
            pc <= pc + 8'd4;
        end
        default: ;
      endcase
    end
  end

  // Register write happens on the WB clock edge; the regfile's own reset
  // has priority, so a reset during WB abandons the write.
  assign reg_we = (state == S_WB) && res_cond_sat && op_writes_rd(iq.opcode);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign wb_valid    = (state == S_WB);

  always_comb begin
    alu_a               = '0;
    alu_b               = '0;
    alu_control         = '0;
    alu_inst_conds      = '0;
    cond_is_zero        = 1'b0;
    cond_is_negative    = 1'b0;
    cond_is_overflow    = 1'b0;
    cond_is_always      = 1'b0;
    cond_update         = 1'b0;
    branch              = 1'b0;
    riscv_branch_offset = '0;
    alu_pc              = '0;
    if (state == S_EXEC) begin
      alu_a          = rdata_a;
      alu_b          = iq.imm_sel ? iq.imm8 : rdata_b;
      alu_control    = iq.opcode;
      alu_inst_conds = cpsr;
      alu_pc         = pc;
      branch         = op_is_branch(iq.opcode);
      cond_update    = iq.s || (iq.opcode == OP_CMP) || (iq.opcode == OP_CMN);
      if (iq.opcode == OP_B) begin
        alu_a = pc;
        alu_b = iq.imm8;
      end
      if ((iq.opcode == OP_BEQ) || (iq.opcode == OP_BNE)) begin
        alu_b               = rdata_b;
        riscv_branch_offset = iq.imm8;
      end
      // Unlisted condition codes leave all four flags low: never execute.
      case (iq.cond)
        COND_EQ: cond_is_zero     = 1'b1;
        COND_MI: cond_is_negative = 1'b1;
        COND_VS: cond_is_overflow = 1'b1;
        COND_AL: cond_is_always   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
